op1_arbiter: RTL

- Round-robin scheduler that shares one operation1 floating-point unit among NUM_REQ command issuers (RoCC decode front-ends, test masters).
- Accepts one 4-operand job at a time and drives the unit's strobe/busy input handshake.
- Collects the unit's result and returns it on a single tagged response channel.
- A watchdog converts a hung unit into an error response.

---
 rtl/op1_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/op1_arbiter.sv
//==============================================================================
// Module   : op1_arbiter
// Purpose  : Round-robin scheduler sharing one operation1 unit among NUM_REQ
//            issuers, with a watchdog that turns a hung unit into an error.
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module op1_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    input  logic [NUM_REQ*DATA_W-1:0]    req_c,
    input  logic [NUM_REQ*DATA_W-1:0]    req_d,
    input  logic [NUM_REQ*5-1:0]         req_rd,
    output logic [DATA_W-1:0]            unit_a,
    output logic [DATA_W-1:0]            unit_b,
    output logic [DATA_W-1:0]            unit_c,
    output logic [DATA_W-1:0]            unit_d,
    output logic                         unit_in_stb,
    input  logic                         unit_in_ack,
    input  logic                         unit_out_stb,
    output logic                         unit_out_busy,
    input  logic [DATA_W-1:0]            unit_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [4:0]                   rsp_rd,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  T_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                orphan_q, orphan_d;
    logic                in_stb_q, in_stb_d;
    logic                out_busy_q, out_busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [4:0]          rsp_rd_q, rsp_rd_d;
    logic [DATA_W-1:0]   ua_q, ua_d, ub_q, ub_d, uc_q, uc_d, ud_q, ud_d;

    logic [2*NUM_REQ-1:0] w_dbl, w_rot;
    logic [IDW:0]         w_shift;
    logic                 w_found;
    logic [IDW-1:0]       w_idx;
    logic [DATA_W-1:0]    w_a, w_b, w_c, w_d;
    logic [4:0]           w_rd;

    // Rotate the doubled request vector so bit 0 is the requester after last_grant.
    assign w_dbl   = {req_valid, req_valid};
    assign w_shift = {1'b0, last_grant_q} + (IDW+1)'(1);
    assign w_rot   = w_dbl >> w_shift;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_idx   = IDW'((int'(last_grant_q) + 1 + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_c  = '0;
        w_d  = '0;
        w_rd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a  = req_a[i*DATA_W +: DATA_W];
                w_b  = req_b[i*DATA_W +: DATA_W];
                w_c  = req_c[i*DATA_W +: DATA_W];
                w_d  = req_d[i*DATA_W +: DATA_W];
                w_rd = req_rd[i*5 +: 5];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == ST_IDLE) && w_found) begin
            req_ready[w_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        orphan_d     = orphan_q;
        in_stb_d     = in_stb_q;
        out_busy_d   = out_busy_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_rd_d     = rsp_rd_q;
        ua_d         = ua_q;
        ub_d         = ub_q;
        uc_d         = uc_q;
        ud_d         = ud_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    ua_d         = w_a;
                    ub_d         = w_b;
                    uc_d         = w_c;
                    ud_d         = w_d;
                    rsp_rd_d     = w_rd;
                    rsp_id_d     = w_idx;
                    last_grant_d = w_idx;
                    in_stb_d     = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (in_stb_q && unit_in_ack) begin
                    in_stb_d   = 1'b0;
                    out_busy_d = 1'b0;
                    timer_d    = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result on the timeout cycle still counts as a normal result.
                if (unit_out_stb && !out_busy_q) begin
                    rsp_data_d  = unit_result;
                    rsp_err_d   = 1'b0;
                    out_busy_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    out_busy_d  = 1'b1;
                    orphan_d    = 1'b1;
                    state_d     = ST_RESP;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (orphan_q) begin
                        out_busy_d = 1'b0;
                        state_d    = ST_FLUSH;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // The late result of a timed-out job is drained and dropped.
                if (unit_out_stb && !out_busy_q) begin
                    out_busy_d = 1'b1;
                    orphan_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_INIT;
            timer_q      <= '0;
            orphan_q     <= 1'b0;
            in_stb_q     <= 1'b0;
            out_busy_q   <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_rd_q     <= '0;
            ua_q         <= '0;
            ub_q         <= '0;
            uc_q         <= '0;
            ud_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            orphan_q     <= orphan_d;
            in_stb_q     <= in_stb_d;
            out_busy_q   <= out_busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rd_q     <= rsp_rd_d;
            ua_q         <= ua_d;
            ub_q         <= ub_d;
            uc_q         <= uc_d;
            ud_q         <= ud_d;
        end
    end

    assign unit_a        = ua_q;
    assign unit_b        = ub_q;
    assign unit_c        = uc_q;
    assign unit_d        = ud_q;
    assign unit_in_stb   = in_stb_q;
    assign unit_out_busy = out_busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire
